// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: source count, FIFO depth,
// ROB tag width and the fixed producer indices.
package cdb_arbiter_pkg;

  localparam int ROB_SZ_LOG  = 4;
  localparam int CDB_NSRC    = 3;
  localparam int CDB_DEPTH   = 2;
  localparam int CDB_TAG_W   = ROB_SZ_LOG + 1;
  localparam int CDB_DATA_W  = 32;

  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;
  localparam int CDB_SRC_BR  = 2;

  // Round-robin search position: the slot `offset` places after `base`, wrapped to n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Shallow per-producer result FIFO holding {tag, data} entries. A push and a pop
// in the same cycle are legal even when full; freeze holds all state.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (!freeze) begin
      if (flush) begin
        wr_ptr <= {PTR_W{1'b0}};
        rd_ptr <= {PTR_W{1'b0}};
        count  <= {CNT_W{1'b0}};
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among NSRC result producers.
// Optional CDB_BYPASS_EN lets a live push into an empty FIFO compete directly.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NSRC   = CDB_NSRC,
  parameter int DEPTH  = CDB_DEPTH,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  parameter int SRC_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   reset,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*TAG_W-1:0]  src_tag,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic [NSRC-1:0]        src_ready,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [SRC_W-1:0]       cdb_src
);

  localparam int ENTRY_W = TAG_W + DATA_W;

  logic [NSRC-1:0]    full, empty, accept, bypass, cand, push, pop;
  logic [ENTRY_W-1:0] head [NSRC];
  logic [SRC_W-1:0]   last_grant, winner;
  logic               grant_valid;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_data;

  assign src_ready = {NSRC{rdy}} & ~full;

  // Candidate set and round-robin winner search starting after last_grant.
  always_comb begin : arb_comb
    int idx;
    grant_valid = 1'b0;
    winner      = {SRC_W{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      accept[i] = src_valid[i] & src_ready[i] & (src_tag[i*TAG_W +: TAG_W] != {TAG_W{1'b0}});
`ifdef CDB_BYPASS_EN
      bypass[i] = accept[i] & empty[i] & ~reset;
`else
      bypass[i] = 1'b0;
`endif
      cand[i] = ~empty[i] | bypass[i];
    end
    for (int k = 0; k < NSRC; k++) begin
      idx = rr_index(int'(last_grant), k + 1, NSRC);
      if (!grant_valid && cand[idx]) begin
        grant_valid = 1'b1;
        winner      = SRC_W'(idx);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Winner payload mux plus per-FIFO push/pop enables.
  always_comb begin
    win_tag  = {TAG_W{1'b0}};
    win_data = {DATA_W{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      pop[i]  = grant_valid & (winner == SRC_W'(i)) & ~empty[i] & ~reset;
      push[i] = accept[i] & ~reset & ~(bypass[i] & grant_valid & (winner == SRC_W'(i)));
      if (grant_valid && (winner == SRC_W'(i))) begin
        if (!empty[i]) begin
          win_tag  = head[i][ENTRY_W-1 -: TAG_W];
          win_data = head[i][DATA_W-1:0];
        end else begin
          win_tag  = src_tag[i*TAG_W +: TAG_W];
          win_data = src_data[i*DATA_W +: DATA_W];
        end
      end else begin
        win_tag  = win_tag;
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .freeze    (~rdy),
      .flush     (reset),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data ({src_tag[g*TAG_W +: TAG_W], src_data[g*DATA_W +: DATA_W]}),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (head[g])
    );
  end

  // Registered CDB broadcast and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= {TAG_W{1'b0}};
      cdb_data   <= {DATA_W{1'b0}};
      cdb_src    <= {SRC_W{1'b0}};
      last_grant <= SRC_W'(NSRC - 1);
    end else if (rdy) begin
      if (reset) begin
        cdb_valid <= 1'b0;
      end else if (grant_valid) begin
        cdb_valid  <= 1'b1;
        cdb_tag    <= win_tag;
        cdb_data   <= win_data;
        cdb_src    <= winner;
        last_grant <= winner;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, CDB_BYPASS_EN undefined).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NSRC = CDB_NSRC;
  localparam int TW   = CDB_TAG_W;
  localparam int DW   = CDB_DATA_W;
  localparam int SW   = 2;

  logic             clk = 1'b0;
  logic             rst, rdy, reset;
  logic [NSRC-1:0]  src_valid;
  logic [NSRC*TW-1:0] src_tag;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC-1:0]  src_ready;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_data;
  logic [SW-1:0]    cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset(reset),
    .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int t);
    return 32'hD000_0000 | 32'(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int t, input logic [31:0] d);
    src_valid[i] = 1'b1;
    src_tag[i*TW +: TW] = TW'(t);
    src_data[i*DW +: DW] = d;
  endtask

  task automatic clr();
    src_valid = '0;
  endtask

  task automatic check_cdb(input string name, input int t, input int s, input logic [31:0] d);
    check_eq({name, "_valid"}, 64'(cdb_valid), 64'd1);
    check_eq({name, "_tag"}, 64'(cdb_tag), 64'(t));
    check_eq({name, "_src"}, 64'(cdb_src), 64'(s));
    check_eq({name, "_data"}, 64'(cdb_data), 64'(d));
  endtask

  task automatic check_idle(input string name);
    check_eq({name, "_valid"}, 64'(cdb_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; reset = 1'b0;
    src_valid = '0; src_tag = '0; src_data = '0;
    step(); step();
    check_eq("rst_valid", 64'(cdb_valid), 64'd0);
    check_eq("rst_tag", 64'(cdb_tag), 64'd0);
    check_eq("rst_data", 64'(cdb_data), 64'd0);
    check_eq("rst_src", 64'(cdb_src), 64'd0);
    check_eq("rst_ready", 64'(src_ready), 64'b111);
    rst = 1'b0;

    // single ALU push: visible after the second edge, gone after the third
    drive(0, 3, 32'h11); step(); clr();
    check_idle("t1_e1");
    step(); check_cdb("t1_e2", 3, 0, 32'h11);
    step(); check_idle("t1_e3");

    // simultaneous pushes after reset: order 0,1,2
    rst = 1'b1; step(); rst = 1'b0;
    drive(0, 1, 32'hA1); drive(1, 2, 32'hA2); drive(2, 3, 32'hA3);
    step(); clr(); check_idle("t2_e1");
    step(); check_cdb("t2_e2", 1, 0, 32'hA1);
    step(); check_cdb("t2_e3", 2, 1, 32'hA2);
    step(); check_cdb("t2_e4", 3, 2, 32'hA3);
    step(); check_idle("t2_e5");

    // source 1 streams, source 0 pushes once
    drive(1, 4, dat(4)); step(); clr(); check_idle("t3_e1");
    drive(1, 5, dat(5)); step(); clr(); check_cdb("t3_e2", 4, 1, dat(4));
    drive(1, 6, dat(6)); drive(0, 7, dat(7)); step(); clr();
    check_cdb("t3_e3", 5, 1, dat(5));
    drive(1, 8, dat(8)); step(); clr();
    check_cdb("t3_e4", 7, 0, dat(7));
    check_eq("t3_ready_full", 64'(src_ready), 64'b101);
    step(); check_cdb("t3_e5", 6, 1, dat(6));
    check_eq("t3_ready_back", 64'(src_ready), 64'b111);
    drive(1, 9, dat(9)); step(); clr(); check_cdb("t3_e6", 8, 1, dat(8));
    step(); check_cdb("t3_e7", 9, 1, dat(9));
    step(); check_idle("t3_e8");

    // fill FIFO 2, then flush with a simultaneous push
    drive(2, 10, dat(10)); drive(0, 20, dat(20)); drive(1, 21, dat(21));
    step(); clr(); check_idle("t4_e1");
    drive(2, 11, dat(11)); step(); clr(); check_cdb("t4_e2", 10, 2, dat(10));
    drive(2, 12, dat(12)); step(); clr(); check_cdb("t4_e3", 20, 0, dat(20));
    check_eq("t4_ready_full", 64'(src_ready), 64'b011);
    reset = 1'b1; drive(1, 13, dat(13)); step(); clr(); reset = 1'b0;
    check_idle("t4_flush");
    check_eq("t4_ready_after", 64'(src_ready), 64'b111);
    for (int i = 0; i < 4; i++) begin
      step(); check_idle("t4_flushed");
    end

    // rdy low freezes a visible broadcast and the pending items
    drive(0, 1, dat(1)); drive(1, 2, dat(2)); drive(2, 3, dat(3));
    step(); clr(); check_idle("t5_e1");
    step(); check_cdb("t5_e2", 2, 1, dat(2));
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_cdb("t5_frozen", 2, 1, dat(2));
      check_eq("t5_ready_frozen", 64'(src_ready), 64'b000);
    end
    rdy = 1'b1;
    step(); check_cdb("t5_r1", 3, 2, dat(3));
    step(); check_cdb("t5_r2", 1, 0, dat(1));
    step(); check_idle("t5_r3");

    // tag 0 push is dropped; a later real push is the only broadcast
    drive(1, 0, 32'h55); step(); clr(); check_idle("t6_e1");
    for (int i = 0; i < 3; i++) begin
      step(); check_idle("t6_none");
      check_eq("t6_ready", 64'(src_ready), 64'b111);
    end
    drive(1, 14, dat(14)); step(); clr(); check_idle("t6_p1");
    step(); check_cdb("t6_p2", 14, 1, dat(14));
    step(); check_idle("t6_p3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among several result producers: ALU, load/store buffer, branch unit.
- Each producer pushes {tag, data} results into a private shallow FIFO.
- A round-robin arbiter pops one head per cycle and broadcasts it on a registered CDB.
- The CDB feeds the reservation-station, LSB and ROB update ports (the run_upd_* / *_rd / *_res inputs).

Parameters:
- NSRC, 3, number of result producers.
- DEPTH, 2, entries per source FIFO (power of two, >=2).
- TAG_W, `ROB_SZ_LOG+1, width of the ROB tag; tag 0 is reserved and means "no dependency".
- DATA_W, 32, result width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  ready; when low the whole block is frozen.
- reset  in  1  branch-mispredict flush; synchronous, active-high.
- src_valid  in  NSRC  per-source push request.
- src_tag  in  NSRC*TAG_W  packed tags; source i occupies bits [i*TAG_W +: TAG_W].
- src_data  in  NSRC*DATA_W  packed results, same packing as src_tag.
- src_ready  out  NSRC  per-source "can accept"; combinational = rdy & ~fifo_full[i].
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast ROB tag (registered).
- cdb_data  out  DATA_W  broadcast result (registered).
- cdb_src  out  clog2(NSRC)  index of the winning source (registered).

Behaviour:
- Push: at a posedge where src_valid[i] & src_ready[i], {tag, data} is written at the FIFO tail. Pushing when not ready is illegal; the bench flags it and the DUT drops the item.
- Tag 0: a push with tag 0 is discarded; no FIFO entry is written.
- Arbitration (combinational, over FIFO heads):
  - Candidates are the non-empty FIFOs.
  - Search order is (last_grant+1) mod NSRC upward, wrapping.
  - The first candidate wins.
- Broadcast:
  - At the posedge, the winner's head is popped into cdb_tag/cdb_data/cdb_src, with cdb_valid<=1, and last_grant<=winner.
  - With no candidate: cdb_valid<=0; data/tag/src hold their old values; last_grant unchanged.
- Latency: an item pushed at edge k into an empty system appears with cdb_valid=1 after edge k+1. Exactly one broadcast per cycle.
- Push and pop on the same FIFO in the same cycle: count unchanged, legal even when full. src_ready stays 0 in that case, because it is derived from the pre-edge count.
- Fairness: any non-empty FIFO is granted within NSRC cycles.
- rst (highest priority): all FIFO counts/pointers 0; cdb_valid=0; cdb_tag=0; cdb_data=0; cdb_src=0; last_grant=NSRC-1, so source 0 has first priority.
- rdy low (below rst, above reset): no state changes, including no pushes or pops; outputs hold their values, including cdb_valid.
- reset (flush) with rdy high:
  - All FIFOs are emptied and cdb_valid<=0 at that edge.
  - Pushes in the same cycle are discarded.
  - last_grant is unchanged.
  - A broadcast already visible during the flush cycle is still consumed by the downstream blocks; the downstream flush handles it.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined: a source whose FIFO is empty and whose src_valid&src_ready is high is also an arbitration candidate, using the live inputs.
  - If it wins, the item goes straight to the CDB registers without a FIFO write, giving 1-edge latency.
  - If it loses, it is pushed normally.
  - FIFO heads keep their round-robin position; bypass only fills an empty slot in the order.
- Undefined: only FIFO heads are candidates, and latency is 2 edges as above.

Decomposition:
- Shared package/def.v gets CDB_NSRC, CDB_DEPTH and source index constants (CDB_SRC_ALU=0, CDB_SRC_LSB=1, CDB_SRC_BR=2). TAG_W reuses ROB_SZ_LOG.
- One sub-module: cdb_src_fifo (DEPTH x {TAG_W, DATA_W}). Interface: push/pop/flush/freeze, with full/empty/head outputs. Instantiated NSRC times via generate.

Test Plan:
- Push ALU {tag 3, 0x11} at edge 1, nothing else → cdb_valid=1, tag 3, data 0x11, src 0 after edge 2; cdb_valid=0 after edge 3. With CDB_BYPASS_EN the same result appears after edge 1.
- All three sources push on the same cycle (tags 1, 2, 3) right after rst → broadcast order src0, src1, src2 on consecutive cycles; last_grant ends at 2.
- Source 1 pushes every cycle, source 0 pushes once → source 0 is granted within 2 cycles. src_ready[1] drops only when 2 entries are pending; no item is lost or duplicated.
- Fill FIFO 2 (2 entries), then assert reset with a simultaneous push → src_ready[2]=1 next cycle, cdb_valid=0, and the flushed tags never appear.
- rdy low for 3 cycles with pending items and a visible broadcast → outputs and counts are frozen; src_ready=0. The broadcast sequence resumes unchanged after rdy rises.
- Push with tag 0 on source 1 → no broadcast ever occurs and the FIFO stays empty.
